class_hv_binarizer_seq: RTL
===========================

Name: class_hv_binarizer_seq

Overview:
- Sequential, parametrised successor to the single-chunk class thresholder.
- Walks every class and every chunk of the non-binary class memory, thresholds each dimension against a runtime-programmable threshold, and streams binarized chunks out on a valid/ready handshake.
- Sits between the non-binary class register bank and the binary associative memory; runs once per training epoch on `start`.

Parameters:
- DIMS_PER_CC, 64, dimensions per chunk (per compute cycle).
- BITWIDTH_PER_DIM, 8, unsigned width of each non-binary dimension counter.
- NUM_CLASSES, 10, number of class hypervectors.
- CHUNKS_PER_HV, 16, chunks per hypervector (total D = DIMS_PER_CC*CHUNKS_PER_HV).

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- en  in  1  global enable; low freezes the FSM and all counters.
- start  in  1  one-cycle pulse; begins a full binarization pass.
- thr  in  BITWIDTH_PER_DIM  threshold; sampled on accepted `start`.
- busy  out  1  high from accepted `start` until `done`.
- done  out  1  one-cycle pulse after the last chunk is accepted.
- rd_en  out  1  read strobe to the class bank.
- rd_class  out  clog2(NUM_CLASSES)  read class index.
- rd_chunk  out  clog2(CHUNKS_PER_HV)  read chunk index.
- rd_data  in  DIMS_PER_CC*BITWIDTH_PER_DIM  read data, valid exactly 1 cycle after `rd_en`.
- out_valid  out  1  binarized chunk valid.
- out_ready  in  1  downstream accept.
- out_class  out  clog2(NUM_CLASSES)  class index of the output chunk.
- out_chunk  out  clog2(CHUNKS_PER_HV)  chunk index of the output chunk.
- out_hv  out  DIMS_PER_CC  binarized chunk.
- pop_valid  out  1  (feature) class popcount valid, one-cycle pulse.
- pop_count  out  clog2(D+1)  (feature) number of ones in the finished class.

Behaviour:
- Clock and reset: one clock, `clk`; reset `nrst` is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; indices and threshold register 0.
- en=0: state, indices, outputs and popcount all hold. `out_valid` stays asserted if already high. A handshake cannot complete while en=0 (out_ready ignored). `rd_data` is sampled only in CAPT with en=1, so the bank must hold read data across stalls.
- FSM states: IDLE, REQ, CAPT, HOLD, DONE.
- IDLE: when start=1, latch `thr`, clear indices and popcount, go to REQ.
- REQ: rd_en=1 with the current indices; go to CAPT.
- CAPT:
  - Per dimension i: out_hv[i] = (rd_data slice i > thr_reg), unsigned strict greater-than.
  - Register out_hv, out_class and out_chunk; set out_valid=1; go to HOLD.
- HOLD: out_valid=1 and outputs stable. On out_valid&out_ready:
  - Clear out_valid.
  - If last chunk of last class, go to DONE.
  - Otherwise advance the chunk index (on wrap, chunk→0 and class+1) and go to REQ.
- DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Throughput: minimum 3 cycles per chunk (REQ, CAPT, HOLD with out_ready already high).
- start while busy: ignored.
- thr changes mid-pass: ignored; thr_reg is fixed for the whole pass.
- Boundary on thr: thr = 2^BITWIDTH_PER_DIM−1 gives all-zero outputs; thr=0 sets exactly the nonzero dims.
- Reset mid-pass: immediate return to reset values; no done pulse.
- Index widths: use clog2 with a minimum of 1 bit.

Optional Feature:
- Macro: CLASS_BIN_POPCNT_EN.
- Defined:
  - Accumulate popcount(out_hv) on each accepted chunk.
  - On acceptance of a class's last chunk, drive pop_count = accumulated total including that chunk, pulse pop_valid for one cycle, and clear the accumulator.
- Undefined: pop_valid and pop_count are tied to 0 and no accumulator logic exists; ports remain present.

Decomposition:
- Shared package holds:
  - DIMS_PER_CC, BITWIDTH_PER_DIM, NUM_CLASSES, CHUNKS_PER_HV.
  - Derived index and popcount widths.
  - FSM state enum typedef.
  - Packed chunk typedef.
- One sub-module: chunk_popcount (combinational adder tree over DIMS_PER_CC bits), instantiated only under CLASS_BIN_POPCNT_EN.

Test Plan:
- Reset mid-pass: assert nrst=0 in HOLD → all outputs 0 and state IDLE; a new start runs a full pass normally.
- thr=3, chunk data {0,3,4,255,…} → out_hv bits {0,0,1,1,…}; out_class/out_chunk match rd_class/rd_chunk from 2 cycles earlier.
- out_ready held low 5 cycles in HOLD → out_valid and out_hv stable throughout; no new rd_en until acceptance.
- Full pass with NUM_CLASSES=2, CHUNKS_PER_HV=3, out_ready=1 → exactly 6 handshakes in order (0,0),(0,1),(0,2),(1,0)…; done pulses once; busy spans the whole pass; a second start during busy is ignored.
- en=0 for 4 cycles in CAPT → indices frozen; the pass completes identically to an unstalled run.
- CLASS_BIN_POPCNT_EN, thr=0, class 0 all dims=1 → pop_valid after chunk (0,2) with pop_count = 3*DIMS_PER_CC; class 1 all zero → pop_count=0.

Source files
------------

// File: rtl/class_hv_binarizer_seq_pkg.sv
// class_hv_binarizer_seq_pkg: shared sizes, derived widths, FSM states and chunk type for the class binarizer
package class_hv_binarizer_seq_pkg;
  localparam int DIMS_PER_CC = 64;
  localparam int BITWIDTH_PER_DIM = 8;
  localparam int NUM_CLASSES = 10;
  localparam int CHUNKS_PER_HV = 16;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int CLS_W = idx_w(NUM_CLASSES);
  localparam int CHK_W = idx_w(CHUNKS_PER_HV);
  localparam int POP_W = idx_w(DIMS_PER_CC * CHUNKS_PER_HV + 1);
  typedef enum logic [2:0] {IDLE, REQ, CAPT, HOLD, DONE} state_t;
  typedef logic [DIMS_PER_CC-1:0] chunk_t;
endpackage

// File: rtl/class_hv_binarizer_seq_chunk_popcount.sv
// chunk_popcount: combinational count of ones across one binarized chunk
module chunk_popcount
  import class_hv_binarizer_seq_pkg::*;
#(
  parameter int W = DIMS_PER_CC,
  parameter int OW = idx_w(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [OW-1:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) count = count + OW'(bits[i]);
  end
endmodule

// File: rtl/class_hv_binarizer_seq.sv
// class_hv_binarizer_seq: streams thresholded class chunks; CLASS_BIN_POPCNT_EN adds per-class popcount
module class_hv_binarizer_seq #(
  parameter int DIMS_PER_CC = class_hv_binarizer_seq_pkg::DIMS_PER_CC,
  parameter int BITWIDTH_PER_DIM = class_hv_binarizer_seq_pkg::BITWIDTH_PER_DIM,
  parameter int NUM_CLASSES = class_hv_binarizer_seq_pkg::NUM_CLASSES,
  parameter int CHUNKS_PER_HV = class_hv_binarizer_seq_pkg::CHUNKS_PER_HV,
  localparam int CLS_W = class_hv_binarizer_seq_pkg::idx_w(NUM_CLASSES),
  localparam int CHK_W = class_hv_binarizer_seq_pkg::idx_w(CHUNKS_PER_HV),
  localparam int POP_W = class_hv_binarizer_seq_pkg::idx_w(DIMS_PER_CC * CHUNKS_PER_HV + 1)
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic                                  en,
  input  logic                                  start,
  input  logic [BITWIDTH_PER_DIM-1:0]           thr,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  rd_en,
  output logic [CLS_W-1:0]                      rd_class,
  output logic [CHK_W-1:0]                      rd_chunk,
  input  logic [DIMS_PER_CC*BITWIDTH_PER_DIM-1:0] rd_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [CLS_W-1:0]                      out_class,
  output logic [CHK_W-1:0]                      out_chunk,
  output logic [DIMS_PER_CC-1:0]                out_hv,
  output logic                                  pop_valid,
  output logic [POP_W-1:0]                      pop_count
);
  import class_hv_binarizer_seq_pkg::*;
  state_t state, nxt;
  logic [CLS_W-1:0] cls;
  logic [CHK_W-1:0] chk;
  logic [BITWIDTH_PER_DIM-1:0] thr_reg;
  logic [DIMS_PER_CC-1:0] bin;
  logic hs, last_chk, last_cls;
  assign hs = en && state == HOLD && out_ready;
  assign last_chk = chk == CHK_W'(CHUNKS_PER_HV - 1);
  assign last_cls = cls == CLS_W'(NUM_CLASSES - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign rd_en = state == REQ;
  assign rd_class = cls;
  assign rd_chunk = chk;
  always_comb begin
    bin = '0;
    for (int i = 0; i < DIMS_PER_CC; i++)
      bin[i] = rd_data[i*BITWIDTH_PER_DIM +: BITWIDTH_PER_DIM] > thr_reg;
  end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? REQ : IDLE;
      REQ:     nxt = CAPT;
      CAPT:    nxt = HOLD;
      HOLD:    nxt = out_ready ? ((last_chk && last_cls) ? DONE : REQ) : HOLD;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      cls <= '0;
      chk <= '0;
      thr_reg <= '0;
      out_valid <= 1'b0;
      out_class <= '0;
      out_chunk <= '0;
      out_hv <= '0;
    end else if (en) begin
      state <= nxt;
      if (state == IDLE && start) begin
        thr_reg <= thr;
        cls <= '0;
        chk <= '0;
      end
      if (state == CAPT) begin
        out_hv <= bin;
        out_class <= cls;
        out_chunk <= chk;
        out_valid <= 1'b1;
      end
      if (hs) begin
        out_valid <= 1'b0;
        if (!(last_chk && last_cls)) begin
          chk <= last_chk ? '0 : chk + 1'b1;
          cls <= last_chk ? cls + 1'b1 : cls;
        end
      end
    end
  end
`ifdef CLASS_BIN_POPCNT_EN
  localparam int PC_W = idx_w(DIMS_PER_CC + 1);
  logic [PC_W-1:0] pc;
  logic [POP_W-1:0] acc, sum;
  chunk_popcount #(.W(DIMS_PER_CC), .OW(PC_W)) u_pc (.bits(out_hv), .count(pc));
  assign sum = acc + POP_W'(pc);
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc <= '0;
      pop_count <= '0;
      pop_valid <= 1'b0;
    end else if (en) begin
      pop_valid <= hs && last_chk;
      if (state == IDLE && start) begin
        acc <= '0;
        pop_count <= '0;
      end else if (hs) begin
        acc <= last_chk ? '0 : sum;
        if (last_chk) pop_count <= sum;
      end
    end
  end
`else
  assign pop_valid = 1'b0;
  assign pop_count = '0;
`endif
endmodule
